// File: rtl/nand_cpu_pkg.sv
// Shared CPU ALU definitions: op encoding, multi-cycle ALU state and LI nibble width.
// Used by alu_mc (optional NAND_ALU_FLAGS_EN zero flag lives in the top).
package nand_cpu_pkg;

  // 4-bit encoding leaves room for undefined codes that the ALU must tolerate.
  typedef enum logic [3:0] {
    CL   = 4'd0,
    CP   = 4'd1,
    NAND = 4'd2,
    LS   = 4'd3,
    RS   = 4'd4,
    EQ   = 4'd5,
    NE   = 4'd6,
    LI   = 4'd7
  } ALU_OP;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_mc_state_e;

  localparam int LI_NIBBLE_W = 4;

endpackage

// File: rtl/alu_mc_shifter.sv
// Combinational shift step: moves acc by at most SHIFT_STEP positions per call.
module alu_mc_shifter #(
  parameter int WIDTH      = 16,
  parameter int SHIFT_STEP = 4
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] rem,
  input  logic             dir,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             last
);

  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(SHIFT_STEP);

  logic [WIDTH-1:0] step_s;

  // dir=1 shifts right; the final partial step consumes whatever remains.
  always_comb begin
    step_s = (rem < STEP_V) ? rem : STEP_V;
    if (dir) begin
      acc_nxt = acc >> step_s;
    end else begin
      acc_nxt = acc << step_s;
    end
    rem_nxt = rem - step_s;
    last    = (rem_nxt == {WIDTH{1'b0}});
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides; shifts iterate through alu_mc_shifter.
// Define NAND_ALU_FLAGS_EN to add the registered zero flag output.
module alu_mc
  import nand_cpu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SHIFT_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op0,
  input  logic [WIDTH-1:0] op1,
  input  ALU_OP            alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef NAND_ALU_FLAGS_EN
  ,
  output logic             zero
`endif
);

  localparam int               IDX_W = $clog2(WIDTH / LI_NIBBLE_W);
  localparam logic [WIDTH-1:0] W_V   = WIDTH'(WIDTH);

  alu_mc_state_e    state_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] rem_r;
  logic             dir_r;
  logic [WIDTH-1:0] result_r;
  logic             out_valid_r;
`ifdef NAND_ALU_FLAGS_EN
  logic             zero_r;
`endif

  logic [WIDTH-1:0] res_s;
  logic             start_shift_s;
  logic             dir_s;
  logic [IDX_W-1:0] idx_s;
  logic             accept_s;
  logic [WIDTH-1:0] sh_acc_s;
  logic [WIDTH-1:0] sh_rem_s;
  logic             sh_last_s;

  assign in_ready  = (state_r == IDLE) && (!out_valid_r || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign result    = result_r;
`ifdef NAND_ALU_FLAGS_EN
  assign zero      = zero_r;
`endif

  alu_mc_shifter #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .acc     (acc_r),
    .rem     (rem_r),
    .dir     (dir_r),
    .acc_nxt (sh_acc_s),
    .rem_nxt (sh_rem_s),
    .last    (sh_last_s)
  );

  // Single-cycle result mux; shifts by 0 or >= WIDTH resolve here without iterating.
  always_comb begin
    res_s         = {WIDTH{1'b0}};
    start_shift_s = 1'b0;
    dir_s         = 1'b0;
    idx_s         = op1[LI_NIBBLE_W +: IDX_W];
    case (alu_op)
      CL:   res_s = {WIDTH{1'b0}};
      CP:   res_s = op0;
      NAND: res_s = ~(op0 & op1);
      EQ:   res_s = {{(WIDTH-1){1'b0}}, (op0 == op1)};
      NE:   res_s = {{(WIDTH-1){1'b0}}, (op0 != op1)};
      LI: begin
        for (int i = 0; i < WIDTH / LI_NIBBLE_W; i++) begin
          res_s[i*LI_NIBBLE_W +: LI_NIBBLE_W] = (idx_s == IDX_W'(i)) ?
              op1[LI_NIBBLE_W-1:0] : op0[i*LI_NIBBLE_W +: LI_NIBBLE_W];
        end
      end
      LS, RS: begin
        dir_s = (alu_op == RS);
        if (op1 == {WIDTH{1'b0}}) begin
          res_s = op0;
        end else if (op1 >= W_V) begin
          res_s = {WIDTH{1'b0}};
        end else begin
          start_shift_s = 1'b1;
        end
      end
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // Control FSM with registered result; an accept may coincide with the output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      dir_r       <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
`ifdef NAND_ALU_FLAGS_EN
      zero_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && start_shift_s) begin
            state_r     <= SHIFT;
            acc_r       <= op0;
            rem_r       <= op1;
            dir_r       <= dir_s;
            out_valid_r <= 1'b0;
          end else if (accept_s) begin
            result_r    <= res_s;
            out_valid_r <= 1'b1;
`ifdef NAND_ALU_FLAGS_EN
            zero_r      <= (res_s == {WIDTH{1'b0}});
`endif
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        SHIFT: begin
          acc_r <= sh_acc_s;
          rem_r <= sh_rem_s;
          if (sh_last_s) begin
            result_r    <= sh_acc_s;
            out_valid_r <= 1'b1;
            state_r     <= IDLE;
`ifdef NAND_ALU_FLAGS_EN
            zero_r      <= (sh_acc_s == {WIDTH{1'b0}});
`endif
          end else begin
            state_r <= SHIFT;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
